// File: rtl/sync_fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_arb_pkg
// Shared definitions for the round-robin FIFO write arbiter:
//   IDLE / GRANT   - arbiter state encoding
//   STAT_WIDTH     - width of each per-producer transfer counter
//   idx_width()    - width of a producer index for a given producer count
// ---------------------------------------------------------------------------
package sync_fifo_arb_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    localparam int STAT_WIDTH = 16;

    // Always at least one bit so a single-producer build still has a legal index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search: returns the first asserted request
// at or after 'start', wrapping modulo NUM_REQ.
// Ports:
//   req    in  NUM_REQ  request vector
//   start  in  IW       index where the search begins
//   found  out 1        at least one request is asserted
//   idx    out IW       winning index (0 when found=0)
// ---------------------------------------------------------------------------
module rr_picker
    import sync_fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      start,
    output logic               found,
    output logic [IW-1:0]      idx
);

    int           pos;
    logic [IW-1:0] pos_idx;

    // Walk from the farthest offset back to the nearest, so the last hit
    // written is the one closest to 'start'.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos     = (int'(start) + k) % NUM_REQ;
            pos_idx = IW'(pos);
            if (req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// sync_fifo_wr_arbiter
// Shares one synchronous FIFO write port among NUM_REQ valid/ready producers.
// One producer holds the grant for at most BURST_MAX transfers; handover is
// round-robin with no bubble cycle when the next producer is already valid.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   req_valid      in   NUM_REQ            per-producer valid
//   req_data       in   NUM_REQ*DATA_WIDTH producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      out  NUM_REQ            per-producer ready (one-hot or zero)
//   fifo_full      in   FIFO full flag
//   fifo_wr_en     out  FIFO write strobe
//   fifo_din       out  DATA_WIDTH         FIFO write data
//   grant_id       out  IW                 current holder, valid while busy=1
//   stat_xfer_cnt  out  NUM_REQ*16         per-producer saturating transfer
//                                          counters (only with
//                                          SYNC_FIFO_ARB_STATS_EN defined)
//   busy           out  a grant is held
//
// Optional feature macro: SYNC_FIFO_ARB_STATS_EN
//
// State table:
//   state | meaning
//   IDLE  | no holder, waiting for any req_valid
//   GRANT | grant_q owns the FIFO write port for up to BURST_MAX transfers
// ---------------------------------------------------------------------------
module sync_fifo_wr_arbiter
    import sync_fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_MAX  = 4,
    localparam int IW         = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [IW-1:0]                 grant_id,
`ifdef SYNC_FIFO_ARB_STATS_EN
    output logic [NUM_REQ*STAT_WIDTH-1:0] stat_xfer_cnt,
`endif
    output logic                          busy
);

    localparam int CW = $clog2(BURST_MAX) + 1;

    logic          state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [CW-1:0] burst_q, burst_d;

    logic          holder_valid;
    logic          xfer;
    logic          release_now;
    logic [IW-1:0] grant_next;
    logic [IW-1:0] pick_start;
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    assign holder_valid = (state_q == GRANT) && req_valid[grant_q];
    assign xfer         = holder_valid && !fifo_full;
    assign release_now  = (state_q == GRANT) &&
                          (!req_valid[grant_q] ||
                           (xfer && (burst_q == CW'(BURST_MAX - 1))));
    assign grant_next   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

    // In IDLE the search starts at rr_ptr; at release it starts just past the
    // current holder, which is the value rr_ptr is about to take.
    assign pick_start = (state_q == GRANT) ? grant_next : rr_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = pick_idx;
                    burst_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_d = grant_next;
                    if (pick_found) begin
                        grant_d = pick_idx;
                        burst_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    burst_d = burst_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q == GRANT);
        grant_id   = grant_q;
        fifo_wr_en = xfer;
        // Forced to zero during reset so the FIFO sees clean data while held.
        fifo_din   = rst_n ? req_data[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == GRANT) && (grant_q == IW'(i)) && !fifo_full;
        end
    end

`ifdef SYNC_FIFO_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [STAT_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (xfer && (grant_q == IW'(i)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign stat_xfer_cnt[i*STAT_WIDTH +: STAT_WIDTH] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_wr_arbiter
// Self-checking bench for sync_fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// BURST_MAX=4). Expected {producer, data} pairs are queued when stimulus is
// set up and popped on each FIFO write. Define SYNC_FIFO_ARB_STATS_EN to also
// exercise the transfer counters.
// ---------------------------------------------------------------------------
module tb_sync_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic [IW-1:0]   grant_id;
    logic            busy;
`ifdef SYNC_FIFO_ARB_STATS_EN
    logic [N*16-1:0] stat_xfer_cnt;
`endif

    sync_fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_din      (fifo_din),
        .grant_id      (grant_id),
`ifdef SYNC_FIFO_ARB_STATS_EN
        .stat_xfer_cnt (stat_xfer_cnt),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;

    int  head [N];
    int  len  [N];
    int  base [N];
    bit  en   [N];
    bit  sb_en;

    logic [11:0] sb_q [$];
    int          wr_cyc [$];

    logic          s_busy;
    logic          s_wr;
    logic [IW-1:0] s_gid;
    logic [N-1:0]  s_ready;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = en[i] && (head[i] < len[i]);
            req_data[i*DW +: DW] = DW'(base[i] + head[i]);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (en[i] && head[i] < len[i]) p = 1'b1;
        return p;
    endfunction

    task automatic clear_prod();
        for (int i = 0; i < N; i++) begin
            head[i] = 0; len[i] = 0; base[i] = 0; en[i] = 1'b0;
        end
        sb_q.delete();
        wr_cyc.delete();
        n_wr      = 0;
        sb_en     = 1'b1;
        fifo_full = 1'b0;
        drive_inputs();
    endtask

    // One clock cycle: sample on the falling edge, advance producers after
    // the rising edge.
    task automatic tick();
        logic [N-1:0] hs;
        logic [11:0]  e;
        @(negedge clk);
        s_busy  = busy;
        s_wr    = fifo_wr_en;
        s_gid   = grant_id;
        s_ready = req_ready;
        hs      = req_valid & req_ready;
        n_checks++;
        if (fifo_wr_en !== (|hs)) begin
            n_fail++;
            $display("FAIL wr_en_vs_handshake: got %b expected %b", fifo_wr_en, |hs);
        end
        if (fifo_wr_en === 1'b1) begin
            n_wr++;
            wr_cyc.push_back(cyc);
            n_checks++;
            if (fifo_full !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_during_full: fifo_wr_en=1 with fifo_full=%b", fifo_full);
            end
            if (sb_en) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got id=%0d data=%02h expected no write", grant_id, fifo_din);
                end else begin
                    e = sb_q.pop_front();
                    if ({4'(grant_id), fifo_din} !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: got id=%0d data=%02h expected id=%0d data=%02h",
                                 grant_id, fifo_din, e[11:8], e[7:0]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (hs[i]) head[i]++;
        drive_inputs();
    endtask

    task automatic run_done(input int budget, input string name);
        int b = 0;
        while (b < budget && (pending() || busy)) begin
            tick();
            b++;
        end
        n_checks++;
        if (pending() || busy) begin
            n_fail++;
            $display("FAIL %s_timeout: got still active after %0d cycles expected idle", name, budget);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_sb_left: got %0d pending writes expected 0", name, sb_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_prod();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_prod();
        for (int i = 0; i < N; i++) begin
            base[i] = 8'hA5; len[i] = 4; en[i] = 1'b1;
        end
        drive_inputs();
        repeat (3) begin
            tick();
            n_checks++;
            if (s_wr !== 1'b0) begin
                n_fail++; $display("FAIL rst_wr_en: got %b expected 0", s_wr);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++;
        if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
        n_checks++;
        if (fifo_din !== 8'h00) begin n_fail++; $display("FAIL rst_din: got %02h expected 00", fifo_din); end
    endtask

    task automatic test_single_producer();
        int c0;
        do_reset();
        base[2] = 8'h10; len[2] = 6; en[2] = 1'b1;
        for (int k = 0; k < 6; k++) sb_q.push_back({4'd2, 8'(8'h10 + k)});
        drive_inputs();
        c0 = cyc;
        tick();
        n_checks++;
        if (s_busy !== 1'b0 || s_ready !== 4'b0000) begin
            n_fail++; $display("FAIL single_no_early_grant: got busy=%b ready=%b expected 0/0000", s_busy, s_ready);
        end
        tick();
        n_checks++;
        if (s_busy !== 1'b1 || s_gid !== 2'd2 || s_ready !== 4'b0100 || s_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got busy=%b id=%0d ready=%b wr=%b expected 1/2/0100/1",
                     s_busy, s_gid, s_ready, s_wr);
        end
        run_done(20, "single");
        n_checks++;
        if (n_wr != 6) begin n_fail++; $display("FAIL single_count: got %0d expected 6", n_wr); end
        if (n_wr == 6) begin
            n_checks++;
            if (wr_cyc[0] != c0 + 1 || wr_cyc[5] != c0 + 6) begin
                n_fail++;
                $display("FAIL single_timing: got first=%0d last=%0d expected %0d/%0d",
                         wr_cyc[0] - c0, wr_cyc[5] - c0, 1, 6);
            end
        end
    endtask

    task automatic test_round_robin();
        int c0;
        do_reset();
        for (int p = 0; p < N; p++) begin
            base[p] = p * 16; len[p] = 8; en[p] = 1'b1;
        end
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++)
                for (int k = 0; k < 4; k++)
                    sb_q.push_back({4'(p), 8'(p * 16 + r * 4 + k)});
        drive_inputs();
        c0 = cyc;
        run_done(60, "rr");
        n_checks++;
        if (n_wr != 32) begin n_fail++; $display("FAIL rr_count: got %0d expected 32", n_wr); end
        if (n_wr == 32) begin
            n_checks++;
            if (wr_cyc[0] != c0 + 1 || wr_cyc[31] != c0 + 32) begin
                n_fail++;
                $display("FAIL rr_back_to_back: got first=%0d last=%0d expected 1/32",
                         wr_cyc[0] - c0, wr_cyc[31] - c0);
            end
        end
    endtask

    task automatic test_full_stall();
        int c0;
        int exp_off [8] = '{1, 2, 8, 9, 10, 11, 13, 14};
        do_reset();
        base[1] = 8'h10; len[1] = 6; en[1] = 1'b1;
        base[2] = 8'h20; len[2] = 2; en[2] = 1'b1;
        for (int k = 0; k < 4; k++) sb_q.push_back({4'd1, 8'(8'h10 + k)});
        sb_q.push_back({4'd2, 8'h20});
        sb_q.push_back({4'd2, 8'h21});
        sb_q.push_back({4'd1, 8'h14});
        sb_q.push_back({4'd1, 8'h15});
        drive_inputs();
        c0 = cyc;
        repeat (3) tick();
        fifo_full = 1'b1;
        repeat (5) begin
            tick();
            n_checks++;
            if (s_ready !== 4'b0000 || s_wr !== 1'b0 || s_gid !== 2'd1 || s_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL full_hold: got ready=%b wr=%b id=%0d busy=%b expected 0000/0/1/1",
                         s_ready, s_wr, s_gid, s_busy);
            end
        end
        fifo_full = 1'b0;
        run_done(30, "full");
        n_checks++;
        if (n_wr != 8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", n_wr); end
        if (n_wr == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (wr_cyc[i] != c0 + exp_off[i]) begin
                    n_fail++;
                    $display("FAIL full_timing[%0d]: got %0d expected %0d", i, wr_cyc[i] - c0, exp_off[i]);
                end
            end
        end
    endtask

    task automatic test_drop_valid();
        do_reset();
        base[3] = 8'h30; len[3] = 3; en[3] = 1'b1;
        sb_q.push_back({4'd3, 8'h30});
        sb_q.push_back({4'd0, 8'h00});
        sb_q.push_back({4'd0, 8'h01});
        drive_inputs();
        tick();
        base[0] = 8'h00; len[0] = 2; en[0] = 1'b1;
        drive_inputs();
        tick();
        n_checks++;
        if (s_gid !== 2'd3 || s_wr !== 1'b1) begin
            n_fail++; $display("FAIL drop_first: got id=%0d wr=%b expected 3/1", s_gid, s_wr);
        end
        en[3] = 1'b0;
        drive_inputs();
        tick();
        n_checks++;
        if (s_busy !== 1'b1 || s_gid !== 2'd3 || s_wr !== 1'b0) begin
            n_fail++; $display("FAIL drop_release: got busy=%b id=%0d wr=%b expected 1/3/0", s_busy, s_gid, s_wr);
        end
        tick();
        n_checks++;
        if (s_gid !== 2'd0 || s_wr !== 1'b1) begin
            n_fail++; $display("FAIL drop_wrap_grant: got id=%0d wr=%b expected 0/1", s_gid, s_wr);
        end
        run_done(10, "drop");
        n_checks++;
        if (n_wr != 3) begin n_fail++; $display("FAIL drop_count: got %0d expected 3", n_wr); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        sb_en   = 1'b0;
        base[0] = 8'h40; len[0] = 8; en[0] = 1'b1;
        drive_inputs();
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 ||
            grant_id !== 2'd0 || fifo_din !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b wr=%b ready=%b id=%0d din=%02h expected 0/0/0000/0/00",
                     busy, fifo_wr_en, req_ready, grant_id, fifo_din);
        end
        clear_prod();
        base[0] = 8'h40; len[0] = 8; en[0] = 1'b1;
        sb_en   = 1'b0;
        drive_inputs();
        repeat (2) begin
            tick();
            n_checks++;
            if (s_wr !== 1'b0) begin n_fail++; $display("FAIL reset_held_wr: got %b expected 0", s_wr); end
        end
        rst_n = 1'b1;
        clear_prod();
        base[1] = 8'h50; len[1] = 2; en[1] = 1'b1;
        base[2] = 8'h60; len[2] = 2; en[2] = 1'b1;
        sb_q.push_back({4'd1, 8'h50});
        sb_q.push_back({4'd1, 8'h51});
        sb_q.push_back({4'd2, 8'h60});
        sb_q.push_back({4'd2, 8'h61});
        drive_inputs();
        tick();
        tick();
        n_checks++;
        if (s_gid !== 2'd1 || s_wr !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_grant: got id=%0d wr=%b expected 1/1", s_gid, s_wr);
        end
        run_done(20, "post_reset");
    endtask

`ifdef SYNC_FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        sb_en   = 1'b0;
        len[0]  = 70000; en[0] = 1'b1;
        drive_inputs();
        run_done(70100, "stats");
        n_checks++;
        if (n_wr != 70000) begin n_fail++; $display("FAIL stats_count: got %0d expected 70000", n_wr); end
        n_checks++;
        if (stat_xfer_cnt[15:0] !== 16'hFFFF) begin
            n_fail++; $display("FAIL stats_sat: got %04h expected ffff", stat_xfer_cnt[15:0]);
        end
        n_checks++;
        if (stat_xfer_cnt[63:16] !== 48'h0) begin
            n_fail++; $display("FAIL stats_others: got %012h expected 0", stat_xfer_cnt[63:16]);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        test_reset();
        test_single_producer();
        test_round_robin();
        test_full_stall();
        test_drop_valid();
        test_reset_mid_burst();
`ifdef SYNC_FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
# sync_fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, forwards that producer's data and write strobe to the FIFO, and honours FIFO full. It sits directly in front of the team's sync FIFO and drives its wr_en/din.

## Interface
- NUM_REQ, 4: number of producers, 2..16
- DATA_WIDTH, 8: payload width; must match the FIFO
- BURST_MAX, 4: maximum transfers per grant, ≥1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-producer valid
- req_data  in  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-producer ready, one-hot or zero
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  DATA_WIDTH  FIFO write data
- grant_id  out  $clog2(NUM_REQ)  index of the current holder; valid only while busy=1
- busy  out  1  a grant is held

## Operation
- States: IDLE (no holder) and GRANT (holder = grant_id). The state, grant_id, round-robin pointer rr_ptr and the burst counter are registered. req_ready, fifo_wr_en and fifo_din are combinational from these registers and the inputs.
- req_ready[i] = busy && grant_id==i && !fifo_full.
- Transfer: req_valid[grant_id] && req_ready[grant_id].
- fifo_wr_en = transfer. fifo_din = req_data slice of grant_id; it is don't-care when fifo_wr_en=0.
- Arbitration is round-robin. The first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ, wins.
- IDLE: if any req_valid is set, register the winner into grant_id, set burst_cnt=0 and go to GRANT. Otherwise stay.
- GRANT, release conditions:
  - (a) a transfer occurs with burst_cnt==BURST_MAX-1, or
  - (b) req_valid[grant_id]=0.
- GRANT, on release:
  - set rr_ptr=(grant_id+1) mod NUM_REQ.
  - Arbitrate in the same cycle using the new pointer over the current req_valid.
  - If there is a winner, load the new grant with burst_cnt=0 and stay in GRANT. If not, go to IDLE.
  - The previous holder may win again only if no other producer is valid.
- GRANT without release: a transfer increments burst_cnt. If fifo_full=1, nothing changes and the grant is held; full never causes a release.
- Producer rule: once valid is asserted, hold valid and data stable until the transfer. Dropping valid early forfeits the grant (condition b) and is legal.
- Reset mid-operation: everything returns to reset values immediately. A partially completed burst is abandoned, and no fifo_wr_en is issued while rst_n=0.
- Reset values: IDLE, busy=0, grant_id=0, rr_ptr=0, burst_cnt=0, req_ready=0, fifo_wr_en=0, fifo_din=0 (held 0 in reset only).

## Timing
- Grant latency from IDLE: valid in cycle t gives ready in cycle t+1, and the first write occurs in t+1 if not full.
- Back-to-back handover between producers: zero bubble cycles. The last write of holder A in cycle t is followed by the first write of holder B in cycle t+1.
- Throughput: one FIFO write per cycle while any producer is valid and the FIFO is not full.
- fifo_wr_en is never asserted in a cycle with fifo_full=1.
- burst_cnt width is $clog2(BURST_MAX)+1. When BURST_MAX=1, every transfer releases.

## Configuration
- SYNC_FIFO_ARB_STATS_EN defined:
  - adds output stat_xfer_cnt, NUM_REQ*16 bits, with per-producer 16-bit transfer counters.
  - Each counter increments on that producer's transfer and saturates at 0xFFFF.
  - Counters reset to 0 on rst_n.
- Undefined: the stat port and counters are absent. The remaining behaviour is identical.

## Structure
- Package sync_fifo_arb_pkg holds:
  - state encoding constants IDLE=1'b0, GRANT=1'b1
  - STAT_WIDTH=16
  - a function computing the index width from NUM_REQ
- Sub-module rr_picker is purely combinational. It takes a request vector and a start pointer, and outputs a found flag and a winner index. It is instantiated once, and its output is used both in IDLE and at release.

## Test plan
- Single producer 2 with 6 words 0x10..0x15, FIFO never full, BURST_MAX=4:
  - grant in the cycle after valid
  - 4 writes, then a release
  - immediate re-grant to 2 (no competitor)
  - 2 more writes; FIFO holds 0x10..0x15 in order
- All 4 producers valid continuously, each with 8 words:
  - grant order 0,1,2,3,0,1,2,3
  - each burst is 4 writes
  - no idle cycle between bursts
  - 32 writes in 32 cycles after the first grant
- fifo_full forced high for 5 cycles in mid-burst of producer 1:
  - req_ready=0 and fifo_wr_en=0 for those cycles
  - grant_id stays 1 and burst_cnt is frozen
  - the burst resumes with the remaining count after full drops
- Producer 3 granted, then drops valid after 1 write while producer 0 is valid:
  - release in the same cycle
  - producer 0 granted with zero bubble, because rr_ptr wraps 3→0
- Reset asserted mid-burst:
  - all outputs go to reset values asynchronously
  - after release of reset with producers 1 and 2 valid, producer 1 is granted first (rr_ptr=0)
- With SYNC_FIFO_ARB_STATS_EN: drive 70000 transfers from producer 0. Counter 0 reads 0xFFFF and the other counters read 0.
